// File: rtl/branch_trap_resolver_if.sv
// Op stream and resolution bus between decode/ALU, the resolver, fetch and the exception unit.
interface branch_trap_resolver_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
);
   logic             op_valid;
   logic             op_ready;
   logic [2:0]       op_kind;
   logic             cond_flag;
   logic             trap_flag;
   logic [PC_W-1:0]  pc;
   logic [15:0]      imm16;
   logic [25:0]      target26;
   logic [PC_W-1:0]  rs_value;
   logic             redirect_valid;
   logic [PC_W-1:0]  redirect_pc;
   logic             link_valid;
   logic [PC_W-1:0]  link_value;
   logic             trap_req;
   logic [PC_W-1:0]  trap_epc;
   logic             trap_in_ds;
   logic             trap_ack;
   logic             ds_error;
   logic [CNT_W-1:0] taken_count;

   // The op producer / exception unit side
   modport master (
      output op_valid, op_kind, cond_flag, trap_flag, pc, imm16, target26, rs_value, trap_ack,
      input  op_ready, redirect_valid, redirect_pc, link_valid, link_value,
             trap_req, trap_epc, trap_in_ds, ds_error, taken_count
   );

   // The resolver side
   modport slave (
      input  op_valid, op_kind, cond_flag, trap_flag, pc, imm16, target26, rs_value, trap_ack,
      output op_ready, redirect_valid, redirect_pc, link_valid, link_value,
             trap_req, trap_epc, trap_in_ds, ds_error, taken_count
   );
endinterface

// File: rtl/branch_trap_resolver.sv
// Resolves MIPS branch/jump redirects with a one-op delay slot, link writes and conditional traps.
module branch_trap_resolver #(
   parameter int CNT_W = 16,
   parameter int PC_W  = 32
) (
   input logic                  clk,
   input logic                  reset,
   branch_trap_resolver_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      TRAP_WAIT
   } state_t;

   state_t          state;
   logic [PC_W-1:0] target_q;
   logic [PC_W-1:0] branch_pc_q;

   logic            accept;
   logic [PC_W-1:0] pc_plus4;
   logic [PC_W-1:0] br_target;
   logic [PC_W-1:0] j_target;
   logic [PC_W-1:0] op_target;
   logic            ctrl_taken;
   logic            is_control;
   logic            is_link;
   logic            trap_taken;

   assign accept   = bus.op_valid && bus.op_ready;
   assign pc_plus4 = bus.pc + PC_W'(4);
   assign br_target = pc_plus4 + {{(PC_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};
   assign j_target  = {pc_plus4[PC_W-1:28], bus.target26, 2'b00};

   // Decode the op kind into taken/link/trap qualifiers and select its target
   always_comb begin
      op_target  = br_target;
      ctrl_taken = 1'b0;
      is_control = 1'b0;
      is_link    = 1'b0;
      trap_taken = 1'b0;
      case (bus.op_kind)
         3'b001: begin is_control = 1'b1; ctrl_taken = bus.cond_flag; end
         3'b010: begin is_control = 1'b1; ctrl_taken = bus.cond_flag; is_link = 1'b1; end
         3'b011: begin is_control = 1'b1; ctrl_taken = 1'b1; op_target = j_target; end
         3'b100: begin is_control = 1'b1; ctrl_taken = 1'b1; op_target = j_target; is_link = 1'b1; end
         3'b101: begin is_control = 1'b1; ctrl_taken = 1'b1; op_target = bus.rs_value; end
         3'b110: begin is_control = 1'b1; ctrl_taken = 1'b1; op_target = bus.rs_value; is_link = 1'b1; end
         3'b111: trap_taken = bus.trap_flag;
         default: ;
      endcase
   end

   // Control FSM with all outputs registered; a control op in the delay slot only flags ds_error
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         target_q           <= '0;
         branch_pc_q        <= '0;
         bus.op_ready       <= 1'b1;
         bus.redirect_valid <= 1'b0;
         bus.redirect_pc    <= '0;
         bus.link_valid     <= 1'b0;
         bus.link_value     <= '0;
         bus.trap_req       <= 1'b0;
         bus.trap_epc       <= '0;
         bus.trap_in_ds     <= 1'b0;
         bus.ds_error       <= 1'b0;
         bus.taken_count    <= '0;
      end else begin
         bus.redirect_valid <= 1'b0;
         bus.link_valid     <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_link) begin
                     bus.link_valid <= 1'b1;
                     bus.link_value <= bus.pc + PC_W'(8);
                  end
                  if (ctrl_taken) begin
                     state       <= DELAY;
                     target_q    <= op_target;
                     branch_pc_q <= bus.pc;
                     if (bus.taken_count != '1) begin
                        bus.taken_count <= bus.taken_count + 1'b1;
                     end
                  end else if (trap_taken) begin
                     state          <= TRAP_WAIT;
                     bus.op_ready   <= 1'b0;
                     bus.trap_req   <= 1'b1;
                     bus.trap_epc   <= bus.pc;
                     bus.trap_in_ds <= 1'b0;
                  end
               end
            end
            DELAY: begin
               if (accept) begin
                  if (trap_taken) begin
                     state          <= TRAP_WAIT;
                     bus.op_ready   <= 1'b0;
                     bus.trap_req   <= 1'b1;
                     bus.trap_epc   <= branch_pc_q;
                     bus.trap_in_ds <= 1'b1;
                  end else begin
                     state              <= IDLE;
                     bus.redirect_valid <= 1'b1;
                     bus.redirect_pc    <= target_q;
                     if (is_control) begin
                        bus.ds_error <= 1'b1;
                     end
                  end
               end
            end
            TRAP_WAIT: begin
               if (bus.trap_ack) begin
                  state          <= IDLE;
                  bus.op_ready   <= 1'b1;
                  bus.trap_req   <= 1'b0;
                  bus.trap_in_ds <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
